ip_encode: RTL

//  IPv4 header generator for the transmit path; counterpart to the receive-side header decoder.
//  On a start pulse it latches source/dest address and payload length, then computes the header

---
 rtl/ip_encode.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/ip_encode.sv
// ip_encode: IPv4 header generator for the transmit path.
// Latches addresses and payload length on start, sums the ten header words
// into a one's-complement checksum, then streams the 20-byte header MSB-first
// on a valid/ready byte interface.
// Optional build macro IP_ENCODE_ID_INC_EN: when defined, a 16-bit
// identification counter advances on every completed header; otherwise the
// identification field is constant zero.
module ip_encode #(
  parameter logic [7:0] TTL      = 8'd64,
  parameter logic [7:0] PROTOCOL = 8'd17,
  parameter bit         DF       = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] sa,
  input  logic [31:0] da,
  input  logic [15:0] payload_len,
  output logic [7:0]  dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CSUM,
    S_SEND
  } state_t;

  localparam logic [15:0] MAX_PAYLOAD = 16'd65515;
  localparam logic [4:0]  LAST_IDX    = 5'd19;
  localparam logic [3:0]  LAST_WORD   = 4'd9;

  state_t      state;
  logic [31:0] sa_q;
  logic [31:0] da_q;
  logic [15:0] tlen_q;
  logic [15:0] id_q;
  logic [15:0] id_src;
  logic [15:0] acc;
  logic [15:0] csum_q;
  logic [3:0]  cnt;
  logic [4:0]  idx;

  logic [15:0] word;
  logic [16:0] sum17;
  logic [15:0] acc_nxt;
  logic [4:0]  idx_nxt;
  logic [7:0]  byte_nxt;
  logic [7:0]  flags_byte;
  logic        last_xfer;

  assign flags_byte = DF ? 8'h40 : 8'h00;
  assign last_xfer  = (state == S_SEND) && dout_valid && dout_ready && (idx == LAST_IDX);

`ifdef IP_ENCODE_ID_INC_EN
  logic [15:0] id_cnt;

  // Identification counter: advances once per completed header
  always_ff @(posedge clk) begin
    if (rst) begin
      id_cnt <= '0;
    end else if (last_xfer) begin
      id_cnt <= id_cnt + 16'd1;
    end
  end

  assign id_src = id_cnt;
`else
  assign id_src = '0;
`endif

  // Header word fed to the checksum adder, in header order with checksum = 0
  always_comb begin
    word = '0;
    case (cnt)
      4'd0:    word = 16'h4500;
      4'd1:    word = tlen_q;
      4'd2:    word = id_q;
      4'd3:    word = {flags_byte, 8'h00};
      4'd4:    word = {TTL, PROTOCOL};
      4'd5:    word = 16'h0000;
      4'd6:    word = sa_q[31:16];
      4'd7:    word = sa_q[15:0];
      4'd8:    word = da_q[31:16];
      4'd9:    word = da_q[15:0];
      default: word = '0;
    endcase
  end

  // One's-complement add: the carry out of bit 15 is folded back into bit 0
  always_comb begin
    sum17   = {1'b0, acc} + {1'b0, word};
    acc_nxt = sum17[15:0] + {15'd0, sum17[16]};
  end

  // Byte to present after the current one is accepted
  always_comb begin
    idx_nxt  = idx + 5'd1;
    byte_nxt = '0;
    case (idx_nxt)
      5'd0:    byte_nxt = 8'h45;
      5'd1:    byte_nxt = 8'h00;
      5'd2:    byte_nxt = tlen_q[15:8];
      5'd3:    byte_nxt = tlen_q[7:0];
      5'd4:    byte_nxt = id_q[15:8];
      5'd5:    byte_nxt = id_q[7:0];
      5'd6:    byte_nxt = flags_byte;
      5'd7:    byte_nxt = 8'h00;
      5'd8:    byte_nxt = TTL;
      5'd9:    byte_nxt = PROTOCOL;
      5'd10:   byte_nxt = csum_q[15:8];
      5'd11:   byte_nxt = csum_q[7:0];
      5'd12:   byte_nxt = sa_q[31:24];
      5'd13:   byte_nxt = sa_q[23:16];
      5'd14:   byte_nxt = sa_q[15:8];
      5'd15:   byte_nxt = sa_q[7:0];
      5'd16:   byte_nxt = da_q[31:24];
      5'd17:   byte_nxt = da_q[23:16];
      5'd18:   byte_nxt = da_q[15:8];
      5'd19:   byte_nxt = da_q[7:0];
      default: byte_nxt = '0;
    endcase
  end

  // Control FSM with registered outputs: IDLE -> CSUM -> SEND -> IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      sa_q       <= '0;
      da_q       <= '0;
      tlen_q     <= '0;
      id_q       <= '0;
      acc        <= '0;
      csum_q     <= '0;
      cnt        <= '0;
      idx        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (payload_len > MAX_PAYLOAD) begin
              err <= 1'b1;
            end else begin
              sa_q   <= sa;
              da_q   <= da;
              tlen_q <= payload_len + 16'd20;
              id_q   <= id_src;
              acc    <= '0;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          acc <= acc_nxt;
          cnt <= cnt + 4'd1;
          if (cnt == LAST_WORD) begin
            csum_q     <= ~acc_nxt;
            idx        <= '0;
            dout       <= 8'h45;
            dout_valid <= 1'b1;
            state      <= S_SEND;
          end
        end
        S_SEND: begin
          if (dout_ready) begin
            if (idx == LAST_IDX) begin
              dout       <= '0;
              dout_valid <= 1'b0;
              done       <= 1'b1;
              busy       <= 1'b0;
              idx        <= '0;
              state      <= S_IDLE;
            end else begin
              idx  <= idx_nxt;
              dout <= byte_nxt;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
